// File: rtl/sliding_window_dilated.sv
// sliding_window_dilated
//   Frame-buffered 2-D window generator. A whole feature map is loaded
//   (raster order: y, x, channel group), then every KERNEL_HEIGHT x
//   KERNEL_WIDTH window is emitted (oy, ox, channel group) with
//   independent stride, dilation, symmetric padding and a pad word.
//
// Ports
//   clk             clock
//   rst             asynchronous reset, active low
//   data_in         packed channel-group word
//   data_in_valid   input beat valid
//   data_in_ready   input beat accepted on valid & ready (LOAD only)
//   data_out        window, element ky*KERNEL_WIDTH+kx is tap (ky,kx)
//   data_out_valid  window valid
//   data_out_ready  downstream accept
//   data_out_first  first window of the frame
//   data_out_last   final window of the frame
//   stall_count     (SLIDING_WINDOW_STALL_CNT_EN only) saturating count of
//                   cycles with data_out_valid & !data_out_ready
//
// Optional feature macro: SLIDING_WINDOW_STALL_CNT_EN
//
// state  | meaning
// S_LOAD | accepting input beats into the frame buffer
// S_EMIT | presenting windows, no input accepted

module sliding_window_dilated #(
    parameter int IMG_WIDTH      = 4,
    parameter int IMG_HEIGHT     = 4,
    parameter int CHANNELS       = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_WIDTH   = 3,
    parameter int KERNEL_HEIGHT  = 3,
    parameter int STRIDE_X       = 1,
    parameter int STRIDE_Y       = 1,
    parameter int DILATION_X     = 1,
    parameter int DILATION_Y     = 1,
    parameter int PADDING_WIDTH  = 1,
    parameter int PADDING_HEIGHT = 1,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [DATA_WIDTH-1:0]                             data_in,
    input  logic                                              data_in_valid,
    output logic                                              data_in_ready,
    output logic [KERNEL_HEIGHT*KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] data_out,
    output logic                                              data_out_valid,
    input  logic                                              data_out_ready,
    output logic                                              data_out_last,
    output logic                                              data_out_first
`ifdef SLIDING_WINDOW_STALL_CNT_EN
    ,
    output logic [31:0]                                       stall_count
`endif
);

    localparam int NUM_X = IMG_WIDTH  + 2*PADDING_WIDTH  - DILATION_X*(KERNEL_WIDTH-1)  - 1;
    localparam int NUM_Y = IMG_HEIGHT + 2*PADDING_HEIGHT - DILATION_Y*(KERNEL_HEIGHT-1) - 1;
    localparam int OUT_X = NUM_X / STRIDE_X + 1;
    localparam int OUT_Y = NUM_Y / STRIDE_Y + 1;
    localparam int NTAP  = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int DEPTH = IMG_HEIGHT * IMG_WIDTH * CHANNELS;
    localparam int AW    = (DEPTH    > 1) ? $clog2(DEPTH)    : 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW    = (OUT_X    > 1) ? $clog2(OUT_X)    : 1;
    localparam int YW    = (OUT_Y    > 1) ? $clog2(OUT_Y)    : 1;

    // Negative numerators truncate toward zero, so they are rejected too.
    if (NUM_X < 0 || NUM_Y < 0 || OUT_X < 1 || OUT_Y < 1) begin : g_bad_geometry
        $fatal(1, "sliding_window_dilated: kernel does not fit the padded image");
    end

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0]             r_buf [DEPTH];
    logic [AW-1:0]                     r_wr_cnt;
    logic                              r_ready_en;
    logic [CW-1:0]                     r_c;
    logic [XW-1:0]                     r_ox;
    logic [YW-1:0]                     r_oy;
    logic [CW-1:0]                     w_nc;
    logic [XW-1:0]                     w_nox;
    logic [YW-1:0]                     w_noy;
    logic [NTAP-1:0][DATA_WIDTH-1:0]   r_dout;
    logic [NTAP-1:0][DATA_WIDTH-1:0]   w_window;
    logic                              r_valid;
    logic                              r_first;
    logic                              r_last;
    logic                              w_in_hs;
    logic                              w_load_done;
    logic                              w_out_hs;
    logic                              w_frame_done;
    logic                              w_advance;
    logic                              w_n_first;
    logic                              w_n_last;

    assign data_in_ready  = r_ready_en && (r_state == S_LOAD);
    assign data_out       = r_dout;
    assign data_out_valid = r_valid;
    assign data_out_first = r_first;
    assign data_out_last  = r_last;

    assign w_in_hs      = data_in_valid && data_in_ready;
    assign w_load_done  = w_in_hs && (r_wr_cnt == AW'(DEPTH - 1));
    assign w_out_hs     = r_valid && data_out_ready;
    assign w_frame_done = w_out_hs && r_last;
    assign w_advance    = w_load_done || (w_out_hs && !r_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_load_done)  w_state_nxt = S_EMIT;
            S_EMIT:  if (w_frame_done) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Position of the window to present next: origin when the frame has
    // just been loaded, otherwise one step past the current window.
    always_comb begin
        w_nc  = '0;
        w_nox = '0;
        w_noy = '0;
        if (r_state == S_EMIT) begin
            w_nc  = r_c;
            w_nox = r_ox;
            w_noy = r_oy;
            if (r_c == CW'(CHANNELS - 1)) begin
                w_nc = '0;
                if (r_ox == XW'(OUT_X - 1)) begin
                    w_nox = '0;
                    if (r_oy == YW'(OUT_Y - 1)) w_noy = '0;
                    else                        w_noy = r_oy + YW'(1);
                end else begin
                    w_nox = r_ox + XW'(1);
                end
            end else begin
                w_nc = r_c + CW'(1);
            end
        end
    end

    assign w_n_first = (w_nc == '0) && (w_nox == '0) && (w_noy == '0);
    assign w_n_last  = (w_nc == CW'(CHANNELS - 1)) && (w_nox == XW'(OUT_X - 1)) &&
                       (w_noy == YW'(OUT_Y - 1));

    // The first window is built on the same edge that writes the final
    // beat, so that beat is forwarded straight from data_in.
    always_comb begin
        int iy;
        int ix;
        int addr;
        iy       = 0;
        ix       = 0;
        addr     = 0;
        w_window = '0;
        for (int ky = 0; ky < KERNEL_HEIGHT; ky++) begin
            for (int kx = 0; kx < KERNEL_WIDTH; kx++) begin
                iy = int'(w_noy) * STRIDE_Y + ky * DILATION_Y - PADDING_HEIGHT;
                ix = int'(w_nox) * STRIDE_X + kx * DILATION_X - PADDING_WIDTH;
                if (iy < 0 || iy >= IMG_HEIGHT || ix < 0 || ix >= IMG_WIDTH) begin
                    w_window[ky*KERNEL_WIDTH+kx] = PAD_VALUE;
                end else begin
                    addr = (iy * IMG_WIDTH + ix) * CHANNELS + int'(w_nc);
                    if (w_in_hs && addr == int'(r_wr_cnt))
                        w_window[ky*KERNEL_WIDTH+kx] = data_in;
                    else
                        w_window[ky*KERNEL_WIDTH+kx] = r_buf[AW'(addr)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[r_wr_cnt] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en <= 1'b0;
            r_wr_cnt   <= '0;
            r_c        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_in_hs) r_wr_cnt <= w_load_done ? '0 : r_wr_cnt + AW'(1);
            if (w_advance) begin
                r_c     <= w_nc;
                r_ox    <= w_nox;
                r_oy    <= w_noy;
                r_dout  <= w_window;
                r_valid <= 1'b1;
                r_first <= w_n_first;
                r_last  <= w_n_last;
            end else if (w_frame_done) begin
                r_c     <= '0;
                r_ox    <= '0;
                r_oy    <= '0;
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

`ifdef SLIDING_WINDOW_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !data_out_ready && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule
